// File: rtl/multicycle_datapath_fsm.sv
// Multicycle MIPS-subset core: IR/A/B/ALUOut/MDR datapath with an embedded
// control FSM, one shared word-addressed memory port (req/ack, any number of
// wait states) and a 32-entry register file with r0 hard-wired to zero.
module multicycle_datapath_fsm #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic              halt,
    output logic [3:0]        state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        WB_R   = 4'd4,
        WB_I   = 4'd5,
        ADDR   = 4'd6,
        MEM_RD = 4'd7,
        WB_MEM = 4'd8,
        MEM_WR = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        HALTED = 4'd12
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [ADDR_W-1:0] PC_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic [DATA_W-1:0] regs_q [32];

    logic              rf_we_s;
    logic [4:0]        rf_waddr_s;
    logic [DATA_W-1:0] rf_wdata_s;
    logic              mem_state_s;
    logic              ack_s;

    // Instruction fields decoded straight from IR.
    logic [5:0]        op_s, funct_s;
    logic [4:0]        rs_s, rt_s, rd_s;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] pc_ext_s;

    assign op_s     = ir_q[31:26];
    assign rs_s     = ir_q[25:21];
    assign rt_s     = ir_q[20:16];
    assign rd_s     = ir_q[15:11];
    assign funct_s  = ir_q[5:0];
    assign imm_s    = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign pc_ext_s = {{(DATA_W-ADDR_W){1'b0}}, pc_q};

    // Memory port: the request is a decode of the state register so a fetch can
    // complete in its very first cycle; gating with reset abandons any pending
    // transaction the moment reset rises. Address/data come straight from
    // registers that hold still while a transaction waits.
    always_comb begin
        mem_state_s = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
        mem_req     = mem_state_s && !reset;
        mem_we      = (state_q == MEM_WR) && !reset;
        if (state_q == FETCH) begin
            mem_addr = pc_q;
        end else begin
            mem_addr = alu_q[ADDR_W-1:0];
        end
        mem_wdata   = b_q;
        ack_s       = mem_req && mem_ack;
    end

    assign pc    = pc_q;
    assign halt  = (state_q == HALTED);
    assign state = state_q;

    // Next-state and datapath register updates for every control step.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        alu_d      = alu_q;
        mdr_d      = mdr_q;
        rf_we_s    = 1'b0;
        rf_waddr_s = 5'd0;
        rf_wdata_s = DATA_ZERO;
        case (state_q)
            FETCH: begin
                if (ack_s) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + PC_ONE;
                    state_d = DECODE;
                end else begin
                    state_d = FETCH;
                end
            end
            DECODE: begin
                a_d   = (rs_s == 5'd0) ? DATA_ZERO : regs_q[rs_s];
                b_d   = (rt_s == 5'd0) ? DATA_ZERO : regs_q[rt_s];
                alu_d = pc_ext_s + imm_s;
                case (op_s)
                    OP_RTYPE: state_d = EXEC_R;
                    OP_ADDI:  state_d = EXEC_I;
                    OP_LW:    state_d = ADDR;
                    OP_SW:    state_d = ADDR;
                    OP_BEQ:   state_d = BRANCH;
                    OP_J:     state_d = JUMP;
                    OP_HALT:  state_d = HALTED;
                    default:  state_d = FETCH;
                endcase
            end
            EXEC_R: begin
                case (funct_s)
                    FN_ADD: begin alu_d = a_q + b_q; state_d = WB_R; end
                    FN_SUB: begin alu_d = a_q - b_q; state_d = WB_R; end
                    FN_AND: begin alu_d = a_q & b_q; state_d = WB_R; end
                    FN_OR:  begin alu_d = a_q | b_q; state_d = WB_R; end
                    FN_SLT: begin
                        alu_d   = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                        state_d = WB_R;
                    end
                    default: state_d = FETCH;
                endcase
            end
            EXEC_I: begin
                alu_d   = a_q + imm_s;
                state_d = WB_I;
            end
            WB_R: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = rd_s;
                rf_wdata_s = alu_q;
                state_d    = FETCH;
            end
            WB_I: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = rt_s;
                rf_wdata_s = alu_q;
                state_d    = FETCH;
            end
            ADDR: begin
                alu_d = a_q + imm_s;
                if (op_s == OP_LW) begin
                    state_d = MEM_RD;
                end else begin
                    state_d = MEM_WR;
                end
            end
            MEM_RD: begin
                if (ack_s) begin
                    mdr_d   = mem_rdata;
                    state_d = WB_MEM;
                end else begin
                    state_d = MEM_RD;
                end
            end
            WB_MEM: begin
                rf_we_s    = 1'b1;
                rf_waddr_s = rt_s;
                rf_wdata_s = mdr_q;
                state_d    = FETCH;
            end
            MEM_WR: begin
                if (ack_s) begin
                    state_d = FETCH;
                end else begin
                    state_d = MEM_WR;
                end
            end
            BRANCH: begin
                if (a_q == b_q) begin
                    pc_d = alu_q[ADDR_W-1:0];
                end else begin
                    pc_d = pc_q;
                end
                state_d = FETCH;
            end
            JUMP: begin
                pc_d    = ir_q[ADDR_W-1:0];
                state_d = FETCH;
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0000_0000;
            a_q     <= DATA_ZERO;
            b_q     <= DATA_ZERO;
            alu_q   <= DATA_ZERO;
            mdr_q   <= DATA_ZERO;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    // Register file; writes to r0 are dropped so it always reads as zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= DATA_ZERO;
            end
        end else if (rf_we_s && (rf_waddr_s != 5'd0)) begin
            regs_q[rf_waddr_s] <= rf_wdata_s;
        end
    end

endmodule

// File: tb/tb_multicycle_datapath_fsm.sv
// Bench for multicycle_datapath_fsm: memory responder with configurable wait
// states, an instruction-level reference model predicting every memory
// transaction and its completion cycle, directed and random programs.
module tb_multicycle_datapath_fsm;

    localparam bit [31:0] HALT_I = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ack, halt;
    logic [15:0] mem_addr, pc;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  state;

    typedef struct {
        bit        we;
        bit [15:0] addr;
        bit [31:0] data;
        int        cyc;
    } txn_t;

    txn_t      dut_log [$];
    txn_t      exp_log [$];
    bit [31:0] tbmem [int];
    bit [31:0] mm [int];
    int        wait_n  = 0;
    bit        stab_en = 1'b0;
    int        cyc     = 0;
    int        n_total = 0;
    int        n_pass  = 0;

    multicycle_datapath_fsm dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pc(pc), .halt(halt), .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit [31:0] i_enc(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt, input bit [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic bit [31:0] r_enc(input bit [4:0] rs, input bit [4:0] rt, input bit [4:0] rd, input bit [5:0] fn);
        return {6'h00, rs, rt, rd, 5'h00, fn};
    endfunction

    function automatic bit [31:0] rdmem(input bit [15:0] a);
        return tbmem.exists(int'(a)) ? tbmem[int'(a)] : 32'h0;
    endfunction

    function automatic bit [31:0] mget(input bit [15:0] a);
        return mm.exists(int'(a)) ? mm[int'(a)] : 32'h0;
    endfunction

    task automatic poke(input bit [15:0] a, input bit [31:0] d);
        tbmem[int'(a)] = d;
        mm[int'(a)]    = d;
    endtask

    // Memory responder: ack after wait_n wait cycles, log completed transactions.
    initial begin : responder
        int        cnt;
        bit [15:0] ca;
        bit        cwe;
        bit [31:0] cwd;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (reset || !mem_req) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else begin
                if (cnt == 0) begin
                    ca = mem_addr; cwe = mem_we; cwd = mem_wdata;
                end else if (stab_en) begin
                    chk("stable_addr", 32'(mem_addr), 32'(ca));
                    chk("stable_we", 32'(mem_we), 32'(cwe));
                    if (cwe) chk("stable_wdata", mem_wdata, cwd);
                end
                if (cnt >= wait_n) begin
                    mem_ack = 1'b1;
                    mem_rdata = cwe ? 32'h0 : rdmem(ca);
                    @(posedge clk);
                    #1;
                    if (!reset) begin
                        dut_log.push_back('{we: cwe, addr: ca, data: (cwe ? cwd : mem_rdata), cyc: cyc});
                        if (cwe) tbmem[int'(ca)] = cwd;
                    end
                    mem_ack = 1'b0;
                    cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    cnt++;
                end
            end
        end
    end

    // Instruction-level reference: architectural effects plus the cycle at
    // which each memory access completes, from the per-instruction costs.
    task automatic model_run(input int w, output int halt_cyc, output bit [15:0] fin_pc);
        bit [31:0] r [32];
        bit [15:0] p, ea;
        bit [31:0] ins, v, sum;
        bit [5:0]  op, fn;
        bit [4:0]  rs, rt, rd;
        bit        done, ok;
        int        t;
        for (int i = 0; i < 32; i++) r[i] = 32'h0;
        p = 16'h0; t = 0; done = 1'b0; halt_cyc = -1;
        exp_log.delete();
        for (int n = 0; n < 500 && !done; n++) begin
            ins = mget(p);
            t += 1 + w;
            exp_log.push_back('{we: 1'b0, addr: p, data: ins, cyc: t});
            p = p + 16'h1;
            op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16]; rd = ins[15:11]; fn = ins[5:0];
            sum = r[rs] + {{16{ins[15]}}, ins[15:0]};
            ea = sum[15:0];
            case (op)
                6'h00: begin
                    ok = 1'b1;
                    case (fn)
                        6'h20: v = r[rs] + r[rt];
                        6'h22: v = r[rs] - r[rt];
                        6'h24: v = r[rs] & r[rt];
                        6'h25: v = r[rs] | r[rt];
                        6'h2A: v = ($signed(r[rs]) < $signed(r[rt])) ? 32'h1 : 32'h0;
                        default: begin ok = 1'b0; v = 32'h0; end
                    endcase
                    if (ok) begin t += 3; if (rd != 5'd0) r[rd] = v; end
                    else t += 2;
                end
                6'h08: begin t += 3; if (rt != 5'd0) r[rt] = sum; end
                6'h23: begin
                    t += 3 + w; v = mget(ea);
                    exp_log.push_back('{we: 1'b0, addr: ea, data: v, cyc: t});
                    t += 1; if (rt != 5'd0) r[rt] = v;
                end
                6'h2B: begin
                    t += 3 + w; mm[int'(ea)] = r[rt];
                    exp_log.push_back('{we: 1'b1, addr: ea, data: r[rt], cyc: t});
                end
                6'h04: begin t += 2; if (r[rs] == r[rt]) p = p + ins[15:0]; end
                6'h02: begin t += 2; p = ins[15:0]; end
                6'h3F: begin t += 1; halt_cyc = t; done = 1'b1; end
                default: t += 1;
            endcase
        end
        fin_pc = p;
    endtask

    task automatic begin_test();
        reset = 1'b1;
        @(posedge clk);
        #1;
        tbmem.delete();
        mm.delete();
    endtask

    task automatic run_prog(input string name, input int w, input bit stab, output int hc_dut);
        int        hc_exp, n;
        bit [15:0] pc_exp;
        wait_n = w; stab_en = stab;
        reset = 1'b1;
        model_run(w, hc_exp, pc_exp);
        @(posedge clk);
        dut_log.delete();
        #2 reset = 1'b0;
        hc_dut = -1;
        for (int c = 0; c < 4000 && hc_dut < 0; c++) begin
            @(posedge clk); #1;
            if (halt) hc_dut = cyc;
        end
        chk({name, "_halt_cycle"}, hc_dut, hc_exp);
        chk({name, "_pc"}, 32'(pc), 32'(pc_exp));
        repeat (4) @(posedge clk);
        #1;
        chk({name, "_idle_req"}, 32'(mem_req), 32'h0);
        chk({name, "_txn_count"}, dut_log.size(), exp_log.size());
        n = (dut_log.size() < exp_log.size()) ? dut_log.size() : exp_log.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_we%0d", name, i), 32'(dut_log[i].we), 32'(exp_log[i].we));
            chk($sformatf("%s_addr%0d", name, i), 32'(dut_log[i].addr), 32'(exp_log[i].addr));
            chk($sformatf("%s_data%0d", name, i), dut_log[i].data, exp_log[i].data);
            chk($sformatf("%s_cyc%0d", name, i), dut_log[i].cyc, exp_log[i].cyc);
        end
    endtask

    function automatic int first_write(input bit [15:0] a);
        for (int i = 0; i < dut_log.size(); i++)
            if (dut_log[i].we && dut_log[i].addr == a) return i;
        return -1;
    endfunction

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int        hc, k, nr, nw;
        bit [31:0] t1, t2, ins;
        bit [4:0]  rs, rt, rd;
        bit [5:0]  fns [5];
        int        seq [6];
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        seq = '{0, 1, 4, 7, 8, 32};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_halt", 32'(halt), 32'h0);
        chk("rst_pc", 32'(pc), 32'h0);

        // Halt at address 0.
        begin_test();
        poke(16'h0, HALT_I);
        run_prog("t1", 0, 1'b0, hc);
        chk("t1_halt_two_edges", hc, 2);
        chk("t1_pc_one", 32'(pc), 32'h1);

        // Arithmetic program, store of the sum.
        begin_test();
        poke(16'd0, i_enc(6'h08, 5'd0, 5'd1, 16'd5));
        poke(16'd1, i_enc(6'h08, 5'd0, 5'd2, 16'hFFFD));
        poke(16'd2, r_enc(5'd1, 5'd2, 5'd3, 6'h20));
        poke(16'd3, r_enc(5'd2, 5'd1, 5'd4, 6'h2A));
        poke(16'd4, i_enc(6'h2B, 5'd0, 5'd3, 16'h10));
        poke(16'd5, HALT_I);
        run_prog("t2", 0, 1'b0, hc);
        k = first_write(16'h10);
        chk("t2_write_seen", 32'(k >= 0), 32'h1);
        if (k >= 0) chk("t2_wdata", dut_log[k].data, 32'h2);
        if (dut_log.size() > 0) chk("t2_halt_addr", 32'(dut_log[dut_log.size()-1].addr), 32'h5);

        // Same, storing the slt result instead.
        begin_test();
        poke(16'd0, i_enc(6'h08, 5'd0, 5'd1, 16'd5));
        poke(16'd1, i_enc(6'h08, 5'd0, 5'd2, 16'hFFFD));
        poke(16'd2, r_enc(5'd1, 5'd2, 5'd3, 6'h20));
        poke(16'd3, r_enc(5'd2, 5'd1, 5'd4, 6'h2A));
        poke(16'd4, i_enc(6'h2B, 5'd0, 5'd4, 16'h11));
        poke(16'd5, HALT_I);
        run_prog("t2b", 1, 1'b1, hc);
        k = first_write(16'h11);
        if (k >= 0) chk("t2b_slt", dut_log[k].data, 32'h1);
        else chk("t2b_write_seen", 32'h0, 32'h1);

        // Load/store with three wait states.
        begin_test();
        poke(16'd0, i_enc(6'h23, 5'd0, 5'd5, 16'h10));
        poke(16'd1, i_enc(6'h2B, 5'd0, 5'd5, 16'h11));
        poke(16'd2, HALT_I);
        poke(16'h10, 32'hDEADBEEF);
        run_prog("t3", 3, 1'b1, hc);
        chk("t3_total_cycles", hc, 26);
        k = first_write(16'h11);
        if (k >= 0) chk("t3_wdata", dut_log[k].data, 32'hDEADBEEF);
        else chk("t3_write_seen", 32'h0, 32'h1);

        // Branches and jump.
        begin_test();
        poke(16'd0, i_enc(6'h08, 5'd0, 5'd1, 16'd5));
        poke(16'd1, i_enc(6'h02, 5'd0, 5'd0, 16'd4));
        poke(16'd2, HALT_I); poke(16'd3, HALT_I);
        poke(16'd4, i_enc(6'h04, 5'd0, 5'd0, 16'd2));
        poke(16'd5, HALT_I); poke(16'd6, HALT_I);
        poke(16'd7, i_enc(6'h04, 5'd1, 5'd0, 16'd2));
        poke(16'd8, i_enc(6'h02, 5'd0, 5'd0, 16'h20));
        poke(16'd9, HALT_I); poke(16'd10, HALT_I);
        poke(16'h20, HALT_I);
        run_prog("t4", 0, 1'b0, hc);
        chk("t4_fetches", dut_log.size(), 6);
        for (int i = 0; i < 6 && i < dut_log.size(); i++)
            chk($sformatf("t4_fetch%0d", i), 32'(dut_log[i].addr), 32'(seq[i]));

        // r0 stays zero.
        begin_test();
        poke(16'd0, i_enc(6'h08, 5'd0, 5'd0, 16'd7));
        poke(16'd1, i_enc(6'h2B, 5'd0, 5'd0, 16'h0));
        poke(16'd2, HALT_I);
        run_prog("t5", 0, 1'b0, hc);
        k = first_write(16'h0);
        if (k >= 0) chk("t5_r0_wdata", dut_log[k].data, 32'h0);
        else chk("t5_write_seen", 32'h0, 32'h1);

        // Random programs.
        for (int r = 0; r < 6; r++) begin
            begin_test();
            for (int j = 0; j < 8; j++) poke(16'h200 + 16'(j), $urandom);
            for (int a = 0; a < 12; a++) begin
                t1 = $urandom; t2 = $urandom;
                rs = {2'b00, t1[2:0]}; rt = {2'b00, t1[5:3]}; rd = {2'b00, t1[8:6]};
                k = int'(t1[13:9]) % 9;
                case (k)
                    0: ins = i_enc(6'h08, rs, rt, t2[15:0]);
                    1, 2, 3, 4, 5: ins = r_enc(rs, rt, rd, fns[k-1]);
                    6: ins = r_enc(rs, rt, rd, 6'h21);
                    7: ins = {6'h0F, t2[25:0]};
                    default: ins = i_enc(6'h23, 5'd0, rt, 16'h200 + {13'h0, t2[2:0]});
                endcase
                poke(16'(a), ins);
            end
            for (int i = 1; i < 8; i++) poke(16'(11 + i), i_enc(6'h2B, 5'd0, 5'(i), 16'h100 + 16'(i)));
            poke(16'd19, HALT_I);
            t1 = $urandom_range(0, 2);
            run_prog($sformatf("rnd%0d", r), int'(t1), 1'b1, hc);
        end

        // Reset during write wait states.
        begin_test();
        poke(16'd0, i_enc(6'h2B, 5'd0, 5'd0, 16'h10));
        poke(16'd1, HALT_I);
        poke(16'h10, 32'h55);
        wait_n = 6; stab_en = 1'b1;
        @(posedge clk);
        dut_log.delete();
        #2 reset = 1'b0;
        k = 0;
        for (int c = 0; c < 100 && k == 0; c++) begin
            @(posedge clk); #1;
            if (mem_req && mem_we) k = 1;
        end
        chk("t7_write_started", 32'(k), 32'h1);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t7_req_dropped", 32'(mem_req), 32'h0);
        nw = 0;
        foreach (dut_log[i]) if (dut_log[i].we) nw++;
        chk("t7_no_write_logged", nw, 0);
        chk("t7_mem_intact", rdmem(16'h10), 32'h55);
        @(posedge clk);
        dut_log.delete();
        #2 reset = 1'b0;
        nr = 0;
        for (int c = 0; c < 30 && nr == 0; c++) begin
            @(posedge clk); #2;
            nr = dut_log.size();
        end
        chk("t7_fetch_seen", nr, 1);
        if (nr > 0) begin
            chk("t7_fetch_addr", 32'(dut_log[0].addr), 32'h0);
            chk("t7_fetch_read", 32'(dut_log[0].we), 32'h0);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
